// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port shared by fifo_wr_arbiter.
// master drives requests and wfull; slave is the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned DSIZE = 8
);
   localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]       req_valid;
   logic [NREQ*DSIZE-1:0] req_data;
   logic [NREQ-1:0]       req_last;
   logic [NREQ-1:0]       req_ready;
   logic [DSIZE-1:0]      fifo_wdata;
   logic                  fifo_winc;
   logic                  fifo_wfull;
   logic [IdW-1:0]        grant_id;
   logic                  busy;

   modport master (
      output req_valid, req_data, req_last, fifo_wfull,
      input  req_ready, fifo_wdata, fifo_winc, grant_id, busy
   );

   modport slave (
      input  req_valid, req_data, req_last, fifo_wfull,
      output req_ready, fifo_wdata, fifo_winc, grant_id, busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter onto the FIFO write port; bursts are never interleaved.
// Optional per-requester stall counters under macro FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DSIZE    = 8,
   parameter int unsigned MAXBURST = 8
) (
   input  logic               wclk,
   input  logic               rrst_n,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic               stats_clr,
   output logic [NREQ*16-1:0] stall_cnt,
`endif
   fifo_wr_arbiter_if.slave   bus
);
   localparam int unsigned IdW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CntW = $clog2(MAXBURST + 1);
   localparam logic [IdW-1:0]  LastId   = IdW'(NREQ - 1);
   localparam logic [CntW-1:0] BeatMax  = CntW'(MAXBURST);
   localparam logic [CntW-1:0] BeatLast = CntW'(MAXBURST - 1);

   typedef enum logic [0:0] {StIdle, StBurst} state_e;

   state_e           state_q;
   logic [IdW-1:0]   rr_ptr_q;
   logic [IdW-1:0]   grant_q;
   logic [CntW-1:0]  beat_cnt_q;
   logic [IdW-1:0]   pick_idx;
   logic             pick_found;
   logic             in_burst;
   logic             xfer;
   logic             burst_end;
   logic [DSIZE-1:0] slice [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         slice[i] = bus.req_data[i*DSIZE +: DSIZE];
      end
   end

   // First valid requester at or after rr_ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned cand;
      cand       = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = (32'(rr_ptr_q) + k) % NREQ;
         if (!pick_found && bus.req_valid[cand[IdW-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = cand[IdW-1:0];
         end
      end
   end

   assign in_burst  = (state_q == StBurst);
   assign xfer      = in_burst & bus.req_valid[grant_q] & ~bus.fifo_wfull;
   assign burst_end = xfer & (bus.req_last[grant_q] | (beat_cnt_q == BeatLast));

   assign bus.fifo_winc  = xfer;
   assign bus.fifo_wdata = in_burst ? slice[grant_q] : '0;
   assign bus.grant_id   = grant_q;
   assign bus.busy       = in_burst;

   always_comb begin
      bus.req_ready = '0;
      if (in_burst) begin
         bus.req_ready[grant_q] = ~bus.fifo_wfull;
      end
   end

   always_ff @(posedge wclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_found) begin
                  grant_q    <= pick_idx;
                  beat_cnt_q <= '0;
                  state_q    <= StBurst;
               end
            end
            StBurst: begin
               if (xfer && beat_cnt_q != BeatMax) begin
                  beat_cnt_q <= beat_cnt_q + 1'b1;
               end
               if (burst_end) begin
                  state_q  <= StIdle;
                  rr_ptr_q <= (grant_q == LastId) ? '0 : grant_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge wclk or negedge rrst_n) begin
      if (!rrst_n) begin
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (stats_clr) begin
               stall_cnt[i*16 +: 16] <= '0;
            end else if (bus.req_valid[i] && !bus.req_ready[i] &&
                         stall_cnt[i*16 +: 16] != 16'hFFFF) begin
               stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif
endmodule
